// File: rtl/neo_sndlatch_if.sv
// 68k<->Z80 sound mailbox signal bundle: strobes, data buses and status flags.
// master = CPU/controller side driving strobes; slave = the latch itself.
interface neo_sndlatch_if #(
  parameter int DATA_W = 8
);
  logic              sndcmdw_n;
  logic              sndrplr_n;
  logic [DATA_W-1:0] m68k_data;
  logic [DATA_W-1:0] rpl_data;
  logic              sdz80r_n;
  logic              sdz80w_n;
  logic              sdz80clr_n;
  logic              nmien_w_n;
  logic              nmidis_w_n;
  logic [DATA_W-1:0] sdd_in;
  logic [DATA_W-1:0] sdd_out;
  logic              z80nmi_n;
  logic              cmd_pending;
  logic              rpl_valid;
  logic              cmd_ovr;

  modport master (
    output sndcmdw_n, sndrplr_n, m68k_data, sdz80r_n, sdz80w_n, sdz80clr_n,
           nmien_w_n, nmidis_w_n, sdd_in,
    input  rpl_data, sdd_out, z80nmi_n, cmd_pending, rpl_valid, cmd_ovr
  );

  modport slave (
    input  sndcmdw_n, sndrplr_n, m68k_data, sdz80r_n, sdz80w_n, sdz80clr_n,
           nmien_w_n, nmidis_w_n, sdd_in,
    output rpl_data, sdd_out, z80nmi_n, cmd_pending, rpl_valid, cmd_ovr
  );
endinterface

// File: rtl/neo_sndlatch.sv
// 68k<->Z80 sound command/reply mailbox with Z80 NMI generation.
// Define SNDLATCH_FIFO_EN to replace the single command latch with a FIFO_DEPTH-entry FIFO.

// One strobe edge detector: acts once per falling (write) or rising (read) edge.
module neo_sndlatch_edge #(
  parameter bit ON_RISE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic armed,
  input  logic strb,
  output logic act
);
  logic prev;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b1;
    else        prev <= strb;

  assign act = armed & (ON_RISE ? (strb & ~prev) : (~strb & prev));
endmodule

module neo_sndlatch #(
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] RESET_CMD  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  neo_sndlatch_if.slave   bus
);
  localparam int NSTB = 7;
  localparam int CMDW = 0, RPLR = 1, Z80R = 2, Z80W = 3, CLR = 4, EN = 5, DIS = 6;
  // Reads complete on the rising edge, everything else acts on the falling edge.
  localparam logic [NSTB-1:0] RISE_MASK = 7'b000_0110;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("neo_sndlatch: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [NSTB-1:0] strb, act;
  logic            armed;

  assign strb = {bus.nmidis_w_n, bus.nmien_w_n, bus.sdz80clr_n, bus.sdz80w_n,
                 bus.sdz80r_n, bus.sndrplr_n, bus.sndcmdw_n};

  // Edges are masked for the first cycle after reset so strobes held low
  // through reset release never fire.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;

  for (genvar i = 0; i < NSTB; i++) begin : g_edge
    neo_sndlatch_edge #(.ON_RISE(RISE_MASK[i])) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .armed (armed),
      .strb  (strb[i]),
      .act   (act[i])
    );
  end

  logic wr_f, rd_r, clr_f;
  assign wr_f  = act[CMDW];
  assign rd_r  = act[Z80R];
  assign clr_f = act[CLR];

  logic pend;
  logic ovr;

`ifdef SNDLATCH_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp, rp;
  logic [DATA_W-1:0] last;
  logic              empty, full, push, pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign push  = wr_f & ~full & ~clr_f;
  assign pop   = rd_r & ~empty & ~clr_f;

  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= bus.m68k_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp   <= '0;
      rp   <= '0;
      last <= RESET_CMD;
      ovr  <= 1'b0;
    end else if (clr_f) begin
      wp   <= '0;
      rp   <= '0;
      last <= RESET_CMD;
      ovr  <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp   <= rp + 1'b1;
        last <= mem[rp[AW-1:0]];
      end
      if (wr_f && full) ovr <= 1'b1;
    end

  assign pend        = ~empty;
  assign bus.sdd_out = empty ? last : mem[rp[AW-1:0]];
`else
  logic [DATA_W-1:0] cmd;

  // A write wins over a same-cycle read; that overlap is not an overrun.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd  <= RESET_CMD;
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else if (clr_f) begin
      cmd  <= RESET_CMD;
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else if (wr_f) begin
      cmd  <= bus.m68k_data;
      pend <= 1'b1;
      if (pend && !rd_r) ovr <= 1'b1;
    end else if (rd_r) begin
      pend <= 1'b0;
    end

  assign bus.sdd_out = cmd;
`endif

  logic [DATA_W-1:0] rpl;
  logic              rpl_vld;
  logic              nmi_en;
  logic              nmi_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rpl     <= '0;
      rpl_vld <= 1'b0;
    end else if (act[Z80W]) begin
      rpl     <= bus.sdd_in;
      rpl_vld <= 1'b1;
    end else if (act[RPLR]) begin
      rpl_vld <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         nmi_en <= 1'b0;
    else if (act[DIS])  nmi_en <= 1'b0;
    else if (act[EN])   nmi_en <= 1'b1;

  // Level-driven from pending+enable, so a command pending at enable time still raises NMI.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) nmi_n <= 1'b1;
    else        nmi_n <= ~(nmi_en & pend);

  assign bus.rpl_data    = rpl;
  assign bus.rpl_valid   = rpl_vld;
  assign bus.cmd_pending = pend;
  assign bus.cmd_ovr     = ovr;
  assign bus.z80nmi_n    = nmi_n;
endmodule

// File: tb/tb_neo_sndlatch.sv
// Self-checking bench for neo_sndlatch: directed mailbox scenarios then random strobes
// against a cycle-level reference model (queue-based in FIFO builds).
module tb_neo_sndlatch;
  localparam int DEPTH = 4;
  localparam int CMDW = 0, RPLR = 1, Z80R = 2, Z80W = 3, CLR = 4, EN = 5, DIS = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neo_sndlatch_if #(.DATA_W(8)) bus ();

  neo_sndlatch #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .RESET_CMD(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] stb;
  logic [7:0] m68k, sdd;
  assign bus.sndcmdw_n  = stb[CMDW];
  assign bus.sndrplr_n  = stb[RPLR];
  assign bus.sdz80r_n   = stb[Z80R];
  assign bus.sdz80w_n   = stb[Z80W];
  assign bus.sdz80clr_n = stb[CLR];
  assign bus.nmien_w_n  = stb[EN];
  assign bus.nmidis_w_n = stb[DIS];
  assign bus.m68k_data  = m68k;
  assign bus.sdd_in     = sdd;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [6:0] pv;
  bit         m_armed, m_pend, m_rv, m_ovr, m_en, m_nmi;
  logic [7:0] m_cmd, m_rpl, m_last;
  logic [7:0] q[$];

  function automatic bit pend_now();
`ifdef SNDLATCH_FIFO_EN
    return q.size() != 0;
`else
    return m_pend;
`endif
  endfunction

  function automatic logic [7:0] exp_sdd();
`ifdef SNDLATCH_FIFO_EN
    return (q.size() != 0) ? q[0] : m_last;
`else
    return m_cmd;
`endif
  endfunction

  task automatic model_reset();
    pv = '1; m_armed = 0; m_pend = 0; m_rv = 0; m_ovr = 0; m_en = 0; m_nmi = 1;
    m_cmd = 8'h00; m_rpl = 8'h00; m_last = 8'h00;
    q.delete();
  endtask

  task automatic model_step();
    logic [6:0] f, r;
    bit was_full;
    f = m_armed ? (~stb & pv) : 7'h00;
    r = m_armed ? (stb & ~pv) : 7'h00;
    pv = stb;
    m_armed = 1;
    m_nmi = !(m_en && pend_now());
`ifdef SNDLATCH_FIFO_EN
    if (f[CLR]) begin
      q.delete(); m_last = 8'h00; m_ovr = 0;
    end else begin
      was_full = (q.size() == DEPTH);
      if (r[Z80R] && q.size() != 0) m_last = q.pop_front();
      if (f[CMDW]) begin
        if (was_full) m_ovr = 1;
        else          q.push_back(m68k);
      end
    end
`else
    was_full = 0;
    if (f[CLR]) begin
      m_cmd = 8'h00; m_pend = 0; m_ovr = 0;
    end else if (f[CMDW]) begin
      if (m_pend && !r[Z80R]) m_ovr = 1;
      m_cmd = m68k; m_pend = 1;
    end else if (r[Z80R]) begin
      m_pend = 0;
    end
`endif
    if (f[Z80W]) begin
      m_rpl = sdd; m_rv = 1;
    end else if (r[RPLR]) begin
      m_rv = 0;
    end
    if (f[DIS])     m_en = 0;
    else if (f[EN]) m_en = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("sdd_out",     bus.sdd_out,     exp_sdd());
    chk("rpl_data",    bus.rpl_data,    m_rpl);
    chk("z80nmi_n",    bus.z80nmi_n,    m_nmi);
    chk("cmd_pending", bus.cmd_pending, pend_now());
    chk("rpl_valid",   bus.rpl_valid,   m_rv);
    chk("cmd_ovr",     bus.cmd_ovr,     m_ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    stb = '1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int idx);
    stb = '1; stb[idx] = 1'b0;
    tick();
    stb[idx] = 1'b1;
    tick();
  endtask

  initial begin
    // Reset with every strobe held low through release
    rst_n = 1'b0; stb = '0; m68k = 8'h00; sdd = 8'h00;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_sdd",  bus.sdd_out, 8'h00);
    chk("rst_rpl",  bus.rpl_data, 8'h00);
    chk("rst_nmi",  bus.z80nmi_n, 1'b1);
    chk("rst_pend", bus.cmd_pending, 1'b0);
    chk("rst_rv",   bus.rpl_valid, 1'b0);
    chk("rst_ovr",  bus.cmd_ovr, 1'b0);
    idle(2);

    // Enabled NMI, command 5A, Z80 reads it
    pulse(EN);
    m68k = 8'h5A; stb[CMDW] = 1'b0; tick();
    chk("cmd_sdd", bus.sdd_out, 8'h5A);
    chk("cmd_pend", bus.cmd_pending, 1'b1);
    chk("cmd_nmi_lag", bus.z80nmi_n, 1'b1);
    stb[CMDW] = 1'b1; tick();
    chk("cmd_nmi", bus.z80nmi_n, 1'b0);
    stb[Z80R] = 1'b0; tick();
    stb[Z80R] = 1'b1; tick();
    chk("rd_pend", bus.cmd_pending, 1'b0);
    tick();
    chk("rd_nmi", bus.z80nmi_n, 1'b1);

    // Two writes without a read, then clear
    m68k = 8'h11; pulse(CMDW);
    m68k = 8'h22; pulse(CMDW);
`ifndef SNDLATCH_FIFO_EN
    chk("ovr_sdd", bus.sdd_out, 8'h22);
    chk("ovr_flag", bus.cmd_ovr, 1'b1);
`endif
    pulse(CLR);
    chk("clr_sdd", bus.sdd_out, 8'h00);
    chk("clr_ovr", bus.cmd_ovr, 1'b0);
    chk("clr_pend", bus.cmd_pending, 1'b0);

    // Reply write coinciding with the 68k read completion of the previous reply
    sdd = 8'h3C; pulse(Z80W);
    chk("rpl_first", bus.rpl_data, 8'h3C);
    stb[RPLR] = 1'b0; tick();
    stb[RPLR] = 1'b1; sdd = 8'hA5; stb[Z80W] = 1'b0; tick();
    chk("rpl_race_data", bus.rpl_data, 8'hA5);
    chk("rpl_race_vld", bus.rpl_valid, 1'b1);
    stb[Z80W] = 1'b1; tick();

    // Disabled NMI, then enable with a command already pending
    pulse(DIS);
    m68k = 8'h33; pulse(CMDW);
    idle(2);
    chk("dis_nmi", bus.z80nmi_n, 1'b1);
    stb[EN] = 1'b0; tick();
    stb[EN] = 1'b1; tick();
    chk("late_en_nmi", bus.z80nmi_n, 1'b0);

    // Enable and disable in the same cycle leaves NMI off
    pulse(CLR);
    pulse(DIS);
    m68k = 8'h44; pulse(CMDW);
    stb[EN] = 1'b0; stb[DIS] = 1'b0; tick();
    idle(2);
    chk("endis_nmi", bus.z80nmi_n, 1'b1);
    chk("endis_pend", bus.cmd_pending, 1'b1);

`ifdef SNDLATCH_FIFO_EN
    // Fill past depth: 5th write dropped, reads return 1..4
    pulse(CLR);
    for (int i = 1; i <= 5; i++) begin
      m68k = 8'(i); pulse(CMDW);
    end
    chk("fifo_ovr", bus.cmd_ovr, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("fifo_head", bus.sdd_out, i);
      pulse(Z80R);
    end
    chk("fifo_empty_pend", bus.cmd_pending, 1'b0);
    chk("fifo_last", bus.sdd_out, 8'h04);
    pulse(Z80R);
    chk("fifo_pop_empty", bus.sdd_out, 8'h04);
`endif

    // Random strobe traffic; clear is kept rare so commands accumulate
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 7; b++)
        stb[b] = (b == CLR) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) != 0);
      m68k = 8'($urandom);
      sdd  = 8'($urandom);
      tick();
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
